pq_cmd_scheduler: RTL and testbench
===================================

# pq_cmd_scheduler

Multi-requester command scheduler for the BRAM-heap priority queue. It arbitrates push/pop/replace requests from NUM_REQ clients round-robin and issues them to the queue as single-cycle i_wrt/i_read pulses. Issued commands are separated by a programmable settle gap so the heap's sift-down FSM completes between them. It tracks occupancy locally, holds off pushes when full and pops/replaces when empty, and returns the popped or replaced top value to the owning requester.

## Interface
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 16, queue element width
- QUEUE_SIZE, 7, queue capacity; must match the attached queue
- ISSUE_GAP, 4, idle cycles after each issued command (>=1)

- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request pending
- req_op  in  2*NUM_REQ  per requester: 01 push, 10 pop, 11 replace, 00 no-op
- req_data  in  NUM_REQ*DATA_WIDTH  push/replace operand
- req_ready  out  NUM_REQ  one-hot, one-cycle grant acknowledge
- resp_valid  out  1  one-cycle pulse carrying pop/replace result
- resp_id  out  max(1,$clog2(NUM_REQ))  requester index of the response
- resp_data  out  DATA_WIDTH  top-of-queue value before the command
- pq_wrt  out  1  to queue i_wrt
- pq_read  out  1  to queue i_read
- pq_data  out  DATA_WIDTH  to queue i_data
- pq_full  in  1  from queue o_full
- pq_empty  in  1  from queue o_empty
- pq_odata  in  DATA_WIDTH  from queue o_data
- count  out  $clog2(QUEUE_SIZE+1)  local occupancy
- busy  out  1  high in ISSUE and GAP
- err_sync  out  1  sticky: local count disagrees with pq_full/pq_empty

## Operation
- FSM states: IDLE, ISSUE, GAP.
  - IDLE -> ISSUE when any requester is eligible.
  - ISSUE -> GAP always.
  - GAP -> IDLE after ISSUE_GAP cycles, counted by a down-counter loaded in ISSUE.
- Eligibility, per requester with req_valid=1:
  - push requires count<QUEUE_SIZE.
  - pop and replace require count>0.
  - no-op is always eligible.
- Ineligible requesters are skipped and stay pending; nothing is dropped.
- Round-robin pointer rr, reset 0. The search starts at rr and wraps modulo NUM_REQ; the first eligible index g wins. On grant, rr <= (g+1) mod NUM_REQ.
- In the IDLE grant cycle, op, data and g are latched.
- No-op: granted (req_ready in the ISSUE cycle), no pq pulse, no response, no count change. GAP still runs.
- ISSUE cycle drives:
  - push: pq_wrt=1, pq_read=0.
  - pop: pq_wrt=0, pq_read=1.
  - replace: pq_wrt=1, pq_read=1.
  - pq_data = latched data, 0 for pop.
  - req_ready[g]=1.
- Count update at the end of ISSUE: push +1, pop -1, replace unchanged. Eligibility rules guarantee no overflow or underflow.
- Pop/replace response: resp_data = pq_odata sampled in the ISSUE cycle; resp_valid=1 and resp_id=g the following cycle.
- Requesters hold req_valid, req_op and req_data stable until req_ready. A request deasserted before grant is withdrawn without effect.
- err_sync is checked each IDLE cycle. It sets when (count==0) != pq_empty or (count==QUEUE_SIZE) != pq_full, and clears only on reset.

## Timing
- Reset: every output is 0, count=0, rr=0, state=IDLE, err_sync=0. A reset mid-ISSUE or mid-GAP aborts with no pulse completed. The queue shares RSTn.
- All outputs are registered; there is no combinational path from req_* to pq_* or req_ready.
- Eligible request visible in IDLE at cycle T:
  - T+1: ISSUE; pq pulse and req_ready.
  - T+2: resp_valid.
  - T+2..T+1+ISSUE_GAP: GAP.
  - T+2+ISSUE_GAP: IDLE.
  - Earliest next pulse at T+3+ISSUE_GAP; peak throughput is one command per ISSUE_GAP+2 cycles.
- pq_wrt/pq_read are never high for two consecutive cycles.
- Simultaneous requests are resolved only by rr. A push blocked by full while a pop is pending lets the pop proceed. The push becomes eligible in the next IDLE.

## Test plan
- Single push: reset, req0 push 0x0050 -> pq_wrt pulse 1 cycle after request, pq_data=0x0050, req_ready[0] same cycle, count=1, no resp_valid.
- Round-robin: req0..3 push 1,2,3,4 all at once -> grants in order 0,1,2,3 with pulses exactly ISSUE_GAP+2 cycles apart; count=4.
- Full hold-off: fill to 7, then req1 push and req2 pop together -> req2 granted first; resp_id=2, resp_data=previous pq_odata; then req1 push granted; count=7.
- Empty hold-off: after reset, req3 pop -> no pulse, req_ready stays 0 for 50 cycles; req0 push 9 -> push issued, then pop issued, resp_data=9.
- Replace: count=3, top 0x00A0; req2 replace 0x0010 -> pq_wrt=pq_read=1 in the same cycle, resp_data=0x00A0, count=3.
- Reset mid-GAP: assert RSTn low during GAP -> all outputs 0, count=0, next request is granted from rr=0.

Source files
------------

// File: rtl/pq_cmd_scheduler.sv
// Round-robin push/pop/replace scheduler in front of the BRAM-heap priority queue.
// One registered command pulse per ISSUE_GAP+2 cycles; occupancy tracked locally.
module pq_cmd_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 7,
  parameter int ISSUE_GAP  = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  output logic [IDW-1:0]                resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          pq_wrt,
  output logic                          pq_read,
  output logic [DATA_WIDTH-1:0]         pq_data,
  input  logic                          pq_full,
  input  logic                          pq_empty,
  input  logic [DATA_WIDTH-1:0]         pq_odata,
  output logic [CW-1:0]                 count,
  output logic                          busy,
  output logic                          err_sync
);

  localparam int SW = IDW + 1;
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam logic [CW-1:0] QS_C   = CW'(QUEUE_SIZE);
  localparam logic [GW-1:0] GAP_LD = GW'(ISSUE_GAP - 1);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         rr_q, rr_d;
  logic [IDW-1:0]         g_q, g_d;
  logic [1:0]             op_q, op_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [CW-1:0]          count_q, count_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   pq_wrt_q, pq_wrt_d;
  logic                   pq_read_q, pq_read_d;
  logic [DATA_WIDTH-1:0]  pq_data_q, pq_data_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [IDW-1:0]         resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [1:0]             op_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_arr[k]   = req_op[2*k +: 2];
    assign data_arr[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  logic                   found;
  logic [IDW-1:0]         gidx;
  logic [1:0]             sel_op;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [SW-1:0]          sum;
  logic [IDW-1:0]         idx;
  logic                   elig;

  // First eligible requester searching upward from rr, wrapping at NUM_REQ.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    sel_op   = OP_NOP;
    sel_data = '0;
    sum      = '0;
    idx      = '0;
    elig     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[IDW-1:0];
      case (op_arr[idx])
        OP_NOP:  elig = req_valid[idx];
        OP_PUSH: elig = req_valid[idx] && (count_q < QS_C);
        default: elig = req_valid[idx] && (count_q != '0);
      endcase
      if (!found && elig) begin
        found    = 1'b1;
        gidx     = idx;
        sel_op   = op_arr[idx];
        sel_data = data_arr[idx];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    g_d          = g_q;
    op_d         = op_q;
    gap_d        = gap_q;
    count_d      = count_q;
    req_ready_d  = '0;
    pq_wrt_d     = 1'b0;
    pq_read_d    = 1'b0;
    pq_data_d    = '0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (((count_q == '0) != pq_empty) || ((count_q == QS_C) != pq_full)) err_d = 1'b1;
        if (found) begin
          state_d           = S_ISSUE;
          g_d               = gidx;
          op_d              = sel_op;
          rr_d              = (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          req_ready_d[gidx] = 1'b1;
          // op bit 0 drives the write strobe, bit 1 the read strobe.
          pq_wrt_d          = sel_op[0];
          pq_read_d         = sel_op[1];
          pq_data_d         = sel_op[0] ? sel_data : '0;
        end
      end
      S_ISSUE: begin
        state_d = S_GAP;
        gap_d   = GAP_LD;
        if (op_q[1]) begin
          resp_valid_d = 1'b1;
          resp_id_d    = g_q;
          resp_data_d  = pq_odata;
        end
        if (op_q == OP_PUSH)     count_d = count_q + 1'b1;
        else if (op_q == OP_POP) count_d = count_q - 1'b1;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      g_q          <= '0;
      op_q         <= OP_NOP;
      gap_q        <= '0;
      count_q      <= '0;
      req_ready_q  <= '0;
      pq_wrt_q     <= 1'b0;
      pq_read_q    <= 1'b0;
      pq_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      g_q          <= g_d;
      op_q         <= op_d;
      gap_q        <= gap_d;
      count_q      <= count_d;
      req_ready_q  <= req_ready_d;
      pq_wrt_q     <= pq_wrt_d;
      pq_read_q    <= pq_read_d;
      pq_data_q    <= pq_data_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign pq_wrt     = pq_wrt_q;
  assign pq_read    = pq_read_q;
  assign pq_data    = pq_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign err_sync   = err_q;

endmodule

// File: tb/tb_pq_cmd_scheduler.sv
// Directed bench for pq_cmd_scheduler with a behavioural max-heap queue model.
module tb_pq_cmd_scheduler;
  localparam int NR = 4, DW = 16, QS = 7, GAP = 4;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic [NR-1:0] req_valid;
  logic [2*NR-1:0] req_op;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic resp_valid;
  logic [1:0] resp_id;
  logic [DW-1:0] resp_data;
  logic pq_wrt, pq_read;
  logic [DW-1:0] pq_data;
  logic pq_full, pq_empty;
  logic [DW-1:0] pq_odata;
  logic [2:0] count;
  logic busy, err_sync;

  logic [NR-1:0] vld_r;
  logic [1:0] op_r [NR];
  logic [DW-1:0] dat_r [NR];
  logic bad;

  assign req_valid = vld_r;
  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign req_op[2*k +: 2]    = op_r[k];
    assign req_data[k*DW +: DW] = dat_r[k];
  end

  always #5 CLK = ~CLK;

  pq_cmd_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .ISSUE_GAP(GAP)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .pq_wrt(pq_wrt), .pq_read(pq_read), .pq_data(pq_data),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_odata(pq_odata),
    .count(count), .busy(busy), .err_sync(err_sync)
  );

  // Max-first queue model; outputs update with nonblocking assigns to avoid edge races.
  logic [DW-1:0] mq [$];
  int mcnt;
  logic [DW-1:0] mtop;
  always @(posedge CLK or negedge RSTn) begin : qmodel
    int pos;
    if (!RSTn) begin
      mq.delete();
      mcnt <= 0;
      mtop <= 16'h0;
    end else begin
      if (pq_read && mq.size() > 0) void'(mq.pop_front());
      if (pq_wrt) begin
        pos = 0;
        while (pos < mq.size() && mq[pos] >= pq_data) pos++;
        mq.insert(pos, pq_data);
      end
      mcnt <= mq.size();
      mtop <= (mq.size() > 0) ? mq[0] : 16'h0;
    end
  end
  assign pq_empty = (mcnt == 0) ^ bad;
  assign pq_full  = (mcnt == QS);
  assign pq_odata = mtop;

  int n_cmp = 0, n_err = 0, cyc = 0, npulse = 0;
  logic prev_pulse = 1'b0;
  int g_log[$], t_log[$], w_log[$], r_log[$], pd_log[$], rid_log[$], rd_log[$], rt_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    g_log.delete(); t_log.delete(); w_log.delete(); r_log.delete(); pd_log.delete();
    rid_log.delete(); rd_log.delete(); rt_log.delete(); npulse = 0;
  endtask

  // Advance one cycle, sample at the falling edge, log grants/responses, drop granted requests.
  task automatic step();
    logic pulse;
    @(negedge CLK);
    cyc++;
    pulse = pq_wrt | pq_read;
    if (pulse) begin
      npulse++;
      chk("no_back_to_back_pulse", {31'b0, prev_pulse}, 0);
    end
    prev_pulse = pulse;
    for (int k = 0; k < NR; k++) begin
      if (req_ready[k]) begin
        g_log.push_back(k); t_log.push_back(cyc);
        w_log.push_back(int'(pq_wrt)); r_log.push_back(int'(pq_read)); pd_log.push_back(int'(pq_data));
        vld_r[k] = 1'b0;
      end
    end
    if (resp_valid) begin
      rid_log.push_back(int'(resp_id)); rd_log.push_back(int'(resp_data)); rt_log.push_back(cyc);
    end
  endtask

  task automatic run_until(input int ngrants, input int budget);
    int n;
    n = 0;
    while (n < budget && !(g_log.size() >= ngrants && !busy)) begin step(); n++; end
    if (n >= budget) chk("timeout_waiting_grants", g_log.size(), ngrants + 1000);
  endtask

  task automatic do_reset();
    vld_r = '0; bad = 1'b0;
    RSTn = 1'b0;
    step(); step();
    chk("rst_ctl", {18'b0, req_ready, resp_valid, resp_id, pq_wrt, pq_read, count, busy, err_sync}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_pq_data", pq_data, 0);
    RSTn = 1'b1;
    prev_pulse = 1'b0;
    clear_logs();
  endtask

  typedef struct {
    int id; logic [1:0] op; logic [15:0] d;
    logic w; logic r; logic [15:0] pd; logic rv; logic [15:0] rd; int cnt;
  } vec_t;
  vec_t tv [8];

  task automatic run_vec(input vec_t v);
    int t0;
    clear_logs();
    op_r[v.id] = v.op; dat_r[v.id] = v.d; vld_r[v.id] = 1'b1;
    t0 = cyc;
    run_until(1, 40);
    chk("grant_count", g_log.size(), 1);
    if (g_log.size() > 0) begin
      chk("grant_id", g_log[0], v.id);
      chk("grant_latency", t_log[0] - t0, 1);
      chk("pq_wrt", w_log[0], {31'b0, v.w});
      chk("pq_read", r_log[0], {31'b0, v.r});
      if (v.w) chk("pq_data", pd_log[0], {16'b0, v.pd});
    end
    chk("resp_count", rid_log.size(), {31'b0, v.rv});
    if (v.rv && rid_log.size() > 0) begin
      chk("resp_id", rid_log[0], v.id);
      chk("resp_data", rd_log[0], {16'b0, v.rd});
      chk("resp_latency", rt_log[0] - t0, 2);
    end
    chk("back_to_idle_cycles", cyc - t0, GAP + 2);
    chk("count", count, v.cnt);
    chk("err_sync_clear", err_sync, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    vld_r = '0; bad = 1'b0;
    for (int k = 0; k < NR; k++) begin op_r[k] = 2'b00; dat_r[k] = '0; end

    //          id op     data     w  r  pq_data  rv resp     cnt
    tv[0] = '{0, 2'b01, 16'h0050, 1, 0, 16'h0050, 0, 16'h0000, 1};
    tv[1] = '{1, 2'b01, 16'h0030, 1, 0, 16'h0030, 0, 16'h0000, 2};
    tv[2] = '{2, 2'b01, 16'h00A0, 1, 0, 16'h00A0, 0, 16'h0000, 3};
    tv[3] = '{2, 2'b11, 16'h0010, 1, 1, 16'h0010, 1, 16'h00A0, 3};
    tv[4] = '{3, 2'b10, 16'h0000, 0, 1, 16'h0000, 1, 16'h0050, 2};
    tv[5] = '{0, 2'b00, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000, 2};
    tv[6] = '{1, 2'b10, 16'h0000, 0, 1, 16'h0000, 1, 16'h0030, 1};
    tv[7] = '{1, 2'b10, 16'h0000, 0, 1, 16'h0000, 1, 16'h0010, 0};

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Round-robin: all four push at once.
    do_reset();
    for (int k = 0; k < NR; k++) begin op_r[k] = 2'b01; dat_r[k] = 16'(k + 1); vld_r[k] = 1'b1; end
    run_until(4, 80);
    chk("rr_grants", g_log.size(), 4);
    if (g_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_order", g_log[k], k);
        chk("rr_pq_data", pd_log[k], k + 1);
        if (k > 0) chk("rr_spacing", t_log[k] - t_log[k-1], GAP + 2);
      end
    end
    chk("rr_count", count, 4);

    // Fill to capacity from req0.
    run_vec('{0, 2'b01, 16'h0005, 1, 0, 16'h0005, 0, 16'h0000, 5});
    run_vec('{0, 2'b01, 16'h0006, 1, 0, 16'h0006, 0, 16'h0000, 6});
    run_vec('{0, 2'b01, 16'h0007, 1, 0, 16'h0007, 0, 16'h0000, 7});

    // Full: rr points at req1 (blocked push), so req2's pop goes first.
    clear_logs();
    op_r[1] = 2'b01; dat_r[1] = 16'h0077; vld_r[1] = 1'b1;
    op_r[2] = 2'b10; dat_r[2] = 16'h0000; vld_r[2] = 1'b1;
    t0 = cyc;
    run_until(2, 60);
    chk("full_grants", g_log.size(), 2);
    if (g_log.size() == 2) begin
      chk("full_first", g_log[0], 2);
      chk("full_second", g_log[1], 1);
      chk("full_first_lat", t_log[0] - t0, 1);
      chk("full_push_data", pd_log[1], 16'h0077);
    end
    chk("full_resp_count", rid_log.size(), 1);
    if (rid_log.size() > 0) begin
      chk("full_resp_id", rid_log[0], 2);
      chk("full_resp_data", rd_log[0], 16'h0007);
    end
    chk("full_count", count, 7);
    chk("full_err_sync", err_sync, 0);

    // Empty: a pop is held off until a push lands.
    do_reset();
    op_r[3] = 2'b10; vld_r[3] = 1'b1;
    for (int i = 0; i < 50; i++) step();
    chk("empty_no_grant", g_log.size(), 0);
    chk("empty_no_pulse", npulse, 0);
    op_r[0] = 2'b01; dat_r[0] = 16'h0009; vld_r[0] = 1'b1;
    run_until(2, 60);
    chk("empty_grants", g_log.size(), 2);
    if (g_log.size() == 2) begin
      chk("empty_first", g_log[0], 0);
      chk("empty_second", g_log[1], 3);
      chk("empty_pop_read", r_log[1], 1);
    end
    chk("empty_resp_count", rid_log.size(), 1);
    if (rid_log.size() > 0) begin
      chk("empty_resp_id", rid_log[0], 3);
      chk("empty_resp_data", rd_log[0], 16'h0009);
    end
    chk("empty_count", count, 0);

    // Reset in GAP, then rr must restart at 0.
    do_reset();
    op_r[1] = 2'b01; dat_r[1] = 16'h0011; vld_r[1] = 1'b1;
    for (int i = 0; i < 10 && g_log.size() == 0; i++) step();
    chk("midgap_granted", g_log.size(), 1);
    step(); step();
    chk("midgap_busy", busy, 1);
    do_reset();
    chk("midgap_count", count, 0);
    op_r[1] = 2'b01; dat_r[1] = 16'h0021; vld_r[1] = 1'b1;
    op_r[3] = 2'b01; dat_r[3] = 16'h0023; vld_r[3] = 1'b1;
    run_until(2, 60);
    chk("midgap_grants", g_log.size(), 2);
    if (g_log.size() == 2) begin
      chk("midgap_first", g_log[0], 1);
      chk("midgap_second", g_log[1], 3);
    end
    chk("midgap_after_count", count, 2);

    // Desync detection: corrupt pq_empty while idle, err_sync is sticky.
    chk("err_before", err_sync, 0);
    bad = 1'b1;
    step(); step();
    chk("err_set", err_sync, 1);
    bad = 1'b0;
    step(); step();
    chk("err_sticky", err_sync, 1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
